// File: rtl/store_check_pkg.sv
// Shared types and constants for the store check monitor.
// Holds the verdict state enum and the fail_code values.
package store_check_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_DATA    = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;
    localparam logic [1:0] FC_ORDER   = 2'b11;

endpackage

// File: rtl/store_check_timer.sv
// RUN-cycle counter with freeze enable and terminal-count compare.
// Ports: clk, reset (sync, high), en (count this cycle),
//        cycle_count (elapsed RUN cycles), timeout_hit (last allowed cycle).
module store_check_timer #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cycle_count,
    output logic             timeout_hit
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (en) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    assign timeout_hit = en && (cycle_count == LAST);

endmodule

// File: rtl/store_check_monitor.sv
// Pass/fail monitor checking an ordered list of expected stores on a CPU
// data-memory bus, with timeout, failure capture and sticky verdicts.
// Ports: clk, reset (sync, high), mem_write/data_addr/write_data (store bus),
//        exp_addr/exp_data (packed expected entries), done/pass/fail,
//        fail_code, check_idx, cycle_count, fail_addr, fail_data.
// Option: define STORE_CHECK_ORDER_EN to fail on stores to later entries.
module store_check_monitor
    import store_check_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int CNT_W          = 32,
    parameter int IDX_W          = $clog2(NUM_CHECKS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_write,
    input  logic [ADDR_W-1:0]            data_addr,
    input  logic [DATA_W-1:0]            write_data,
    input  logic [NUM_CHECKS*ADDR_W-1:0] exp_addr,
    input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic [1:0]                   fail_code,
    output logic [IDX_W-1:0]             check_idx,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [ADDR_W-1:0]            fail_addr,
    output logic [DATA_W-1:0]            fail_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);

    state_t            state;
    state_t            state_nx;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_nx;
    logic [1:0]        fc_q;
    logic [1:0]        fc_nx;
    logic [ADDR_W-1:0] faddr_q;
    logic [ADDR_W-1:0] faddr_nx;
    logic [DATA_W-1:0] fdata_q;
    logic [DATA_W-1:0] fdata_nx;

    logic              run;
    logic              timeout_hit;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic              cur_hit;
    logic              later_hit;

    store_check_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .en          (run),
        .cycle_count (cycle_count),
        .timeout_hit (timeout_hit)
    );

    // Select the current entry with an explicit compare so an index of
    // NUM_CHECKS (after PASS) never reads outside the packed vectors.
    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int k = 0; k < NUM_CHECKS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_addr = exp_addr[k*ADDR_W +: ADDR_W];
                cur_data = exp_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign cur_hit = mem_write && (data_addr == cur_addr);

`ifdef STORE_CHECK_ORDER_EN
    always_comb begin
        later_hit = 1'b0;
        for (int k = 0; k < NUM_CHECKS; k++) begin
            if ((IDX_W'(k) > idx_q) &&
                (data_addr == exp_addr[k*ADDR_W +: ADDR_W])) begin
                later_hit = 1'b1;
            end
        end
        later_hit = later_hit && mem_write && !cur_hit;
    end
`else
    assign later_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            idx_q   <= '0;
            fc_q    <= FC_NONE;
            faddr_q <= '0;
            fdata_q <= '0;
        end else begin
            state   <= state_nx;
            idx_q   <= idx_nx;
            fc_q    <= fc_nx;
            faddr_q <= faddr_nx;
            fdata_q <= fdata_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx_q;
        fc_nx    = fc_q;
        faddr_nx = faddr_q;
        fdata_nx = fdata_q;
        unique case (state)
            ST_RUN: begin
                if (cur_hit) begin
                    if (write_data == cur_data) begin
                        idx_nx = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_nx = ST_PASS;
                        end
                    end else begin
                        state_nx = ST_FAIL;
                        fc_nx    = FC_DATA;
                        faddr_nx = data_addr;
                        fdata_nx = write_data;
                    end
                end else if (later_hit) begin
                    state_nx = ST_FAIL;
                    fc_nx    = FC_ORDER;
                    faddr_nx = data_addr;
                    fdata_nx = write_data;
                end
                // A non-final match on the last cycle still times out;
                // only reaching PASS or an earlier failure pre-empts it.
                if (timeout_hit && (state_nx == ST_RUN)) begin
                    state_nx = ST_FAIL;
                    fc_nx    = FC_TIMEOUT;
                end
            end
            ST_PASS: state_nx = ST_PASS;
            ST_FAIL: state_nx = ST_FAIL;
            default: state_nx = ST_RUN;
        endcase
    end

    always_comb begin
        run  = 1'b0;
        pass = 1'b0;
        fail = 1'b0;
        unique case (state)
            ST_RUN:  run  = 1'b1;
            ST_PASS: pass = 1'b1;
            ST_FAIL: fail = 1'b1;
            default: run  = 1'b0;
        endcase
        done = pass | fail;
    end

    assign check_idx = idx_q;
    assign fail_code = fc_q;
    assign fail_addr = faddr_q;
    assign fail_data = fdata_q;

endmodule

// File: doc/store_check_monitor.md
# store_check_monitor

Reusable pass/fail monitor for CPU self-checking simulations. It sits on the data-memory store bus of a CPU top (`mem_write`, `data_addr`, `write_data`) and checks a parametrised, ordered list of expected (address, data) stores. It replaces single hard-coded "address 100, data 25" checks with N ordered checks, a cycle-accurate timeout, diagnostic capture and sticky verdict outputs. It is synthesizable; the bench only reads its outputs and prints or finishes.

## Interface
- `ADDR_W`, 32: store address width.
- `DATA_W`, 32: store data width.
- `NUM_CHECKS`, 4: number of expected stores, ≥1.
- `TIMEOUT_CYCLES`, 10000: RUN cycles allowed before a timeout failure, ≥1.
- `CNT_W`, 32: cycle counter width; must represent `TIMEOUT_CYCLES`.
- `IDX_W`, `$clog2(NUM_CHECKS+1)`: width of the check index (derived).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_write`  in  1  store strobe from the CPU.
- `data_addr`  in  `ADDR_W`  store address.
- `write_data`  in  `DATA_W`  store data.
- `exp_addr`  in  `NUM_CHECKS*ADDR_W`  expected addresses, entry k at bits [k*ADDR_W +: ADDR_W]. Static during a run.
- `exp_data`  in  `NUM_CHECKS*DATA_W`  expected data, same packing.
- `done`  out  1  verdict reached (pass or fail).
- `pass`  out  1  all checks matched in order.
- `fail`  out  1  failure detected.
- `fail_code`  out  2  00 none, 01 data mismatch, 10 timeout, 11 order violation.
- `check_idx`  out  `IDX_W`  number of checks matched so far.
- `cycle_count`  out  `CNT_W`  RUN cycles elapsed since reset release.
- `fail_addr`  out  `ADDR_W`  address of the failing store; 0 if none.
- `fail_data`  out  `DATA_W`  data of the failing store; 0 if none.

## Operation
- States: RUN, PASS, FAIL. PASS and FAIL are sticky until `reset`.
- Reset (synchronous): state RUN. All outputs are 0, `check_idx`=0 and `cycle_count`=0. Stores sampled while `reset`=1 are ignored.
- RUN, evaluated every cycle in this priority:
  1. `mem_write` and `data_addr`==`exp_addr[check_idx]`:
     - If `write_data`==`exp_data[check_idx]`: increment `check_idx`. If it was `NUM_CHECKS-1`, go to PASS.
     - Otherwise: go to FAIL with code 01 and capture the store in `fail_addr`/`fail_data`.
  2. Order check (only when `STORE_CHECK_ORDER_EN` is compiled in): `mem_write` with `data_addr` equal to `exp_addr[j]` for some j > `check_idx`, and not equal to the current entry. Result: FAIL with code 11 and the store captured.
  3. Timeout: `cycle_count`==`TIMEOUT_CYCLES-1` and no transition to PASS this cycle. Result: FAIL with code 10; `fail_addr`/`fail_data` stay 0.
- Any other store is ignored.
- Duplicate expected addresses: only the current entry is compared, so repeated addresses are checked in sequence.
- `cycle_count` increments in every RUN cycle and freezes on entering PASS or FAIL.
- `done` = `pass` | `fail`. `pass` and `fail` are never both 1.

## Timing
- Latency is one cycle. A qualifying store sampled at edge n produces the updated `check_idx`, `pass` or `fail` after edge n.
- Timeout: with no matching stores, `fail` rises after exactly `TIMEOUT_CYCLES` RUN cycles, and `cycle_count` freezes at `TIMEOUT_CYCLES`.
- If the final match and the timeout fall in the same cycle, the final match wins and the state goes to PASS.
- Reset asserted mid-run or in PASS/FAIL: the next edge returns the block to the reset values.
- Inputs are sampled only on the clock edge, so mid-cycle changes on the store bus are ignored.

## Configuration
- `STORE_CHECK_ORDER_EN` defined: out-of-order stores to any later expected address are flagged as FAIL with code 11.
- Macro undefined: such stores are ignored, so only data mismatches on the current entry and timeout can fail. Code 11 is never produced.

## Structure
- Package `store_check_pkg` holds:
  - the state enum (RUN, PASS, FAIL);
  - the `fail_code` constants FC_NONE, FC_DATA, FC_TIMEOUT, FC_ORDER.
- Sub-module `store_check_timer` contains the `cycle_count` register, its freeze enable and the terminal-count compare. It outputs `cycle_count` and a `timeout_hit` pulse.

## Test plan
Common setup: `NUM_CHECKS`=2, entries (100, 25) and (104, 7), `TIMEOUT_CYCLES`=50.
- Ordered pass: reset for 2 cycles, store (100, 25), later store (104, 7). Required: `pass`=1 and `done`=1 one cycle after the second store, `check_idx`=2, `fail_code`=00, `cycle_count` frozen.
- Data mismatch: store (100, 26). Required: `fail`=1 next cycle, `fail_code`=01, `fail_addr`=100, `fail_data`=26, `check_idx`=0.
- Timeout: no stores. Required: `fail`=1 after 50 RUN cycles, `fail_code`=10, `cycle_count`=50 and stable thereafter.
- Irrelevant stores: stores to 96 and 200 interleaved with the two correct stores. Required: ignored; the run ends in PASS.
- Order violation: store (104, 7) first.
  - With `STORE_CHECK_ORDER_EN`: `fail_code`=11, `fail_addr`=104.
  - Without it: ignored, `check_idx` stays 0, and the run ends in timeout.
- Reset mid-run: after (100, 25) matches, assert `reset` for 1 cycle while driving store (104, 7). Required: `check_idx`=0, `cycle_count`=0 and all flags 0; the store under reset is ignored.
